// File: rtl/psl_job_pkg.sv
// psl_job_pkg: shared command codes, reset-sequencer states and jerror bit map.
package psl_job_pkg;
    localparam logic [7:0] CMD_START    = 8'h90;
    localparam logic [7:0] CMD_RESET    = 8'h80;
    localparam logic [7:0] CMD_TIMEBASE = 8'h42;
    localparam int ERR_JCOM_PAR = 0;
    localparam int ERR_JEA_PAR  = 1;
    localparam int ERR_ABORT    = 2;
    localparam int ERR_BUSY     = 3;
    localparam int ERR_ENG_LSB  = 8;
    typedef enum logic [2:0] {IDLE, QUIESCE, PRE, ASSERT, DONE} rst_state_t;
    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction
endpackage

// File: rtl/psl_reset_seq.sv
// psl_reset_seq: quiesce, pre-reset wait, engine reset pulse and one-cycle done.
module psl_reset_seq
    import psl_job_pkg::*;
#(
    parameter int QUIESCE_CYCLES   = 1024,
    parameter int PRE_RST_CYCLES   = 4,
    parameter int RST_PULSE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_reset_cmd,
    output logic o_eng_rstb,
    output logic o_reset_done,
    output logic o_idle
);
    localparam int CW = $clog2(max3(QUIESCE_CYCLES, PRE_RST_CYCLES, RST_PULSE_CYCLES) + 1);
    localparam logic [CW-1:0] Q_LAST = CW'(QUIESCE_CYCLES - 1);
    localparam logic [CW-1:0] P_LAST = CW'(PRE_RST_CYCLES - 1);
    localparam logic [CW-1:0] A_LAST = CW'(RST_PULSE_CYCLES - 1);

    rst_state_t      r_state, w_next;
    logic [CW-1:0]   r_cnt, w_cnt_next;
    logic            r_rstb;

    always_comb begin
        w_next = r_state;
        case (r_state)
            QUIESCE: w_next = (r_cnt == Q_LAST) ? PRE : QUIESCE;
            PRE:     w_next = (r_cnt == P_LAST) ? ASSERT : PRE;
            ASSERT:  w_next = (r_cnt == A_LAST) ? DONE : ASSERT;
            default: w_next = IDLE;
        endcase
        if (i_reset_cmd) w_next = QUIESCE;
        w_cnt_next = (i_reset_cmd || w_next != r_state || r_state == IDLE) ? '0 : r_cnt + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rstb  <= 1'b1;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_rstb  <= (w_next != ASSERT);
        end
    end

    assign o_eng_rstb   = r_rstb;
    assign o_reset_done = (r_state == DONE);
    assign o_idle       = (r_state == IDLE);
endmodule

// File: rtl/psl_job_ctrl_mc.sv
// psl_job_ctrl_mc: PSL job command decode, multi-engine fan-out and jdone/jerror aggregation.
module psl_job_ctrl_mc
    import psl_job_pkg::*;
#(
    parameter logic [7:0] START_CMD    = CMD_START,
    parameter logic [7:0] RESET_CMD    = CMD_RESET,
    parameter logic [7:0] TIMEBASE_CMD = CMD_TIMEBASE,
    parameter int NUM_ENG          = 4,
    parameter int QUIESCE_CYCLES   = 1024,
    parameter int PRE_RST_CYCLES   = 4,
    parameter int RST_PULSE_CYCLES = 4,
    parameter int CHECK_PARITY     = 1
) (
    input  logic               ha_pclock,
    input  logic               CPU_RESETn,
    input  logic               ha_jval,
    input  logic [7:0]         ha_jcom,
    input  logic               ha_jcompar,
    input  logic [63:0]        ha_jea,
    input  logic               ha_jeapar,
    input  logic [7:0]         ha_croom,
    input  logic [NUM_ENG-1:0] eng_finished,
    input  logic [NUM_ENG-1:0] eng_abort,
    output logic               ah_jrunning,
    output logic               ah_jdone,
    output logic [63:0]        ah_jerror,
    output logic               ah_jcack,
    output logic               ah_jyield,
    output logic               ah_tbreq,
    output logic               ah_paren,
    output logic [63:0]        wed,
    output logic [7:0]         num_credits,
    output logic               eng_start,
    output logic               eng_rstb,
    output logic               reset_cmd_received
);
    logic               w_jcom_ok, w_jea_ok, w_start, w_tb, w_busy, w_start_ok;
    logic               w_rej_new, w_cmp_new, w_rst_done, w_seq_idle;
    logic               w_have_rd, w_have_rej, w_have_cmp, w_free;
    logic               w_sel_rd, w_sel_rej, w_sel_cmp;
    logic [63:0]        w_rej_err, w_cmp_err, w_rej_cand, w_cmp_cand;
    logic [NUM_ENG-1:0] w_fin_n, w_ab_n, r_fin, r_ab;
    logic               r_running, r_jdone, r_tbreq, r_eng_start;
    logic               r_pd_rd, r_pd_rej, r_pd_cmp;
    logic [63:0]        r_jerror, r_wed, r_pd_rej_err, r_pd_cmp_err;
    logic [7:0]         r_credits;

    psl_reset_seq #(
        .QUIESCE_CYCLES   (QUIESCE_CYCLES),
        .PRE_RST_CYCLES   (PRE_RST_CYCLES),
        .RST_PULSE_CYCLES (RST_PULSE_CYCLES)
    ) u_seq (
        .i_clk        (ha_pclock),
        .i_rst_n      (CPU_RESETn),
        .i_reset_cmd  (reset_cmd_received),
        .o_eng_rstb   (eng_rstb),
        .o_reset_done (w_rst_done),
        .o_idle       (w_seq_idle)
    );

    assign w_jcom_ok          = (CHECK_PARITY == 0) || ^{ha_jcom, ha_jcompar};
    assign w_jea_ok           = (CHECK_PARITY == 0) || ^{ha_jea, ha_jeapar};
    assign reset_cmd_received = ha_jval && ha_jcom == RESET_CMD;
    assign w_start            = ha_jval && ha_jcom == START_CMD;
    assign w_tb               = ha_jval && ha_jcom == TIMEBASE_CMD;
    assign w_busy             = r_running || !w_seq_idle;
    assign w_start_ok         = w_start && !w_busy && w_jcom_ok && w_jea_ok;
    assign w_rej_new          = (w_start && !w_start_ok)
                              || (ha_jval && !w_start && !w_tb && !reset_cmd_received && !w_jcom_ok);
    assign w_rej_err          = w_start ? ((64'(w_busy) << ERR_BUSY) | (64'(!w_jea_ok) << ERR_JEA_PAR)
                                           | (64'(!w_jcom_ok) << ERR_JCOM_PAR))
                                        : (64'd1 << ERR_JCOM_PAR);
    // engine inputs only count while a job is already running, so a Start cycle ignores them
    assign w_fin_n            = r_fin | eng_finished;
    assign w_ab_n             = r_ab | eng_abort;
    assign w_cmp_new          = r_running && !reset_cmd_received && (&w_fin_n || |w_ab_n);
    assign w_cmp_err          = (64'(w_ab_n) << ERR_ENG_LSB) | (64'(|w_ab_n) << ERR_ABORT);

    assign w_have_rd  = w_rst_done || r_pd_rd;
    assign w_have_rej = !reset_cmd_received && (w_rej_new || r_pd_rej);
    assign w_have_cmp = !reset_cmd_received && (w_cmp_new || r_pd_cmp);
    assign w_free     = !r_jdone;
    assign w_sel_rd   = w_free && w_have_rd;
    assign w_sel_rej  = w_free && !w_have_rd && w_have_rej;
    assign w_sel_cmp  = w_free && !w_have_rd && !w_have_rej && w_have_cmp;
    assign w_rej_cand = r_pd_rej ? r_pd_rej_err : w_rej_err;
    assign w_cmp_cand = r_pd_cmp ? r_pd_cmp_err : w_cmp_err;

    always_ff @(posedge ha_pclock or negedge CPU_RESETn) begin
        if (!CPU_RESETn) begin
            r_running    <= 1'b0;
            r_jdone      <= 1'b0;
            r_jerror     <= '0;
            r_tbreq      <= 1'b0;
            r_eng_start  <= 1'b0;
            r_wed        <= '0;
            r_credits    <= '0;
            r_fin        <= '0;
            r_ab         <= '0;
            r_pd_rd      <= 1'b0;
            r_pd_rej     <= 1'b0;
            r_pd_cmp     <= 1'b0;
            r_pd_rej_err <= '0;
            r_pd_cmp_err <= '0;
        end else begin
            r_running    <= (reset_cmd_received || w_cmp_new) ? 1'b0 : (w_start_ok || r_running);
            r_eng_start  <= w_start_ok;
            r_tbreq      <= w_tb && w_jcom_ok;
            r_jdone      <= w_sel_rd || w_sel_rej || w_sel_cmp;
            r_jerror     <= w_sel_rej ? w_rej_cand : (w_sel_cmp ? w_cmp_cand : '0);
            r_pd_rd      <= w_have_rd && !w_sel_rd;
            // a fresh event arriving while the held one issues takes over the pending slot
            r_pd_rej     <= w_have_rej && (!w_sel_rej || (r_pd_rej && w_rej_new));
            r_pd_cmp     <= w_have_cmp && (!w_sel_cmp || (r_pd_cmp && w_cmp_new));
            r_pd_rej_err <= (r_pd_rej && !w_sel_rej) ? r_pd_rej_err : w_rej_err;
            r_pd_cmp_err <= (r_pd_cmp && !w_sel_cmp) ? r_pd_cmp_err : w_cmp_err;
            if (w_start_ok) begin
                r_wed     <= ha_jea;
                r_credits <= ha_croom;
                r_fin     <= '0;
                r_ab      <= '0;
            end else if (r_running) begin
                r_fin <= w_fin_n;
                r_ab  <= w_ab_n;
            end
        end
    end

    assign ah_jrunning = r_running;
    assign ah_jdone    = r_jdone;
    assign ah_jerror   = r_jerror;
    assign ah_jcack    = 1'b0;
    assign ah_jyield   = 1'b0;
    assign ah_tbreq    = r_tbreq;
    assign ah_paren    = (CHECK_PARITY != 0);
    assign wed         = r_wed;
    assign num_credits = r_credits;
    assign eng_start   = r_eng_start;
endmodule

// File: tb/tb_psl_job_ctrl_mc.sv
// tb_psl_job_ctrl_mc: randomized jobs and reset sequences against a queue scoreboard of jdone events.
module tb_psl_job_ctrl_mc;
    localparam int NE = 4;
    localparam logic [7:0] C_START = 8'h90;
    localparam logic [7:0] C_RESET = 8'h80;
    localparam logic [7:0] C_TB    = 8'h42;
    localparam logic [7:0] C_UNK   = 8'h55;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ha_jval = 1'b0, ha_jcompar = 1'b0, ha_jeapar = 1'b0;
    logic [7:0]    ha_jcom = '0, ha_croom = '0;
    logic [63:0]   ha_jea = '0;
    logic [NE-1:0] eng_finished = '0, eng_abort = '0;
    logic          ah_jrunning, ah_jdone, ah_jcack, ah_jyield, ah_tbreq, ah_paren;
    logic          eng_start, eng_rstb, reset_cmd_received;
    logic [63:0]   ah_jerror, wed;
    logic [7:0]    num_credits;

    int            n_chk = 0, n_pass = 0;
    logic [63:0]   exp_q[$];
    logic          prev_jdone = 1'b0;

    always #5 clk = ~clk;

    psl_job_ctrl_mc #(
        .NUM_ENG(NE), .QUIESCE_CYCLES(16), .PRE_RST_CYCLES(4), .RST_PULSE_CYCLES(4), .CHECK_PARITY(1)
    ) dut (
        .ha_pclock(clk), .CPU_RESETn(rst_n), .ha_jval(ha_jval), .ha_jcom(ha_jcom),
        .ha_jcompar(ha_jcompar), .ha_jea(ha_jea), .ha_jeapar(ha_jeapar), .ha_croom(ha_croom),
        .eng_finished(eng_finished), .eng_abort(eng_abort), .ah_jrunning(ah_jrunning),
        .ah_jdone(ah_jdone), .ah_jerror(ah_jerror), .ah_jcack(ah_jcack), .ah_jyield(ah_jyield),
        .ah_tbreq(ah_tbreq), .ah_paren(ah_paren), .wed(wed), .num_credits(num_credits),
        .eng_start(eng_start), .eng_rstb(eng_rstb), .reset_cmd_received(reset_cmd_received)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ah_jdone) begin
                chk("jdone_spacing", 64'(prev_jdone), 64'd0);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL jdone_unexpected: got jerror %h, no event expected", ah_jerror);
                end else chk("jerror", ah_jerror, exp_q.pop_front());
            end else chk("jerror_idle", ah_jerror, 64'd0);
        end
        prev_jdone <= ah_jdone;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] c, input logic [63:0] ea, input logic [7:0] cr,
                         input bit bjc, input bit bje);
        ha_jval = 1'b1;
        ha_jcom = c;
        ha_jcompar = ~^c ^ bjc;
        ha_jea = ea;
        ha_jeapar = ~^ea ^ bje;
        ha_croom = cr;
    endtask

    task automatic send(input logic [7:0] c, input logic [63:0] ea, input logic [7:0] cr,
                        input bit bjc, input bit bje);
        drive(c, ea, cr, bjc, bje);
        cyc();
        ha_jval = 1'b0;
    endtask

    // called one cycle after a Reset command was sampled; expects the 16+4 quiesce then a 4-cycle pulse
    task automatic reset_seq(input int stop_at, input bit collide);
        for (int k = 1; k <= stop_at; k++) begin
            if (k == 25) begin
                exp_q.push_back(64'd0);
                if (collide) begin
                    drive(C_START, 64'h1234, 8'h1, 1'b0, 1'b0);
                    exp_q.push_back(64'h8);
                end
            end
            cyc();
            ha_jval = 1'b0;
            chk("eng_rstb", 64'(eng_rstb), 64'(!(k >= 20 && k < 24)));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0]   ea;
        logic [7:0]    cr;
        logic [NE-1:0] fin, ab, f, a;
        bit            busy_done, allow_ab, done, bjc, bje;

        repeat (3) cyc();
        chk("rst_jrunning", 64'(ah_jrunning), 0);
        chk("rst_jdone", 64'(ah_jdone), 0);
        chk("rst_jerror", ah_jerror, 0);
        chk("rst_tbreq", 64'(ah_tbreq), 0);
        chk("rst_wed", wed, 0);
        chk("rst_credits", 64'(num_credits), 0);
        chk("rst_eng_start", 64'(eng_start), 0);
        chk("rst_eng_rstb", 64'(eng_rstb), 1);
        chk("paren", 64'(ah_paren), 1);
        chk("jcack_jyield", {ah_jcack, ah_jyield}, 0);
        rst_n = 1'b1;
        cyc();

        exp_q.push_back(64'h2);
        send(C_START, 64'hDEAD_BEEF_0000_1000, 8'h40, 1'b0, 1'b1);
        chk("badjea_running", 64'(ah_jrunning), 0);
        chk("badjea_wed", wed, 0);
        chk("badjea_eng_start", 64'(eng_start), 0);
        repeat (2) cyc();
        exp_q.push_back(64'h1);
        send(C_START, 64'h77, 8'h2, 1'b1, 1'b0);
        repeat (2) cyc();
        exp_q.push_back(64'h3);
        send(C_START, 64'h77, 8'h2, 1'b1, 1'b1);
        repeat (2) cyc();
        exp_q.push_back(64'h1);
        send(C_UNK, 64'h0, 8'h0, 1'b1, 1'b0);
        repeat (2) cyc();
        send(C_UNK, 64'h0, 8'h0, 1'b0, 1'b1);
        chk("wed_after_rejects", wed, 0);
        send(C_TB, 64'h0, 8'h0, 1'b0, 1'b0);
        chk("tbreq_high", 64'(ah_tbreq), 1);
        cyc();
        chk("tbreq_low", 64'(ah_tbreq), 0);
        repeat (2) cyc();

        send(C_START, 64'hDEAD_BEEF_0000_1000, 8'h40, 1'b0, 1'b0);
        chk("job1_wed", wed, 64'hDEAD_BEEF_0000_1000);
        chk("job1_credits", 64'(num_credits), 64'h40);
        chk("job1_running", 64'(ah_jrunning), 1);
        chk("job1_eng_start", 64'(eng_start), 1);
        for (int k = 1; k <= 20; k++) begin
            eng_finished = (k == 5) ? 4'b0001 : (k == 9) ? 4'b0010 : (k == 12) ? 4'b0100 : (k == 20) ? 4'b1000 : 4'b0000;
            if (k == 20) exp_q.push_back(64'd0);
            cyc();
            if (k == 1) chk("job1_eng_start_pulse", 64'(eng_start), 0);
            chk("job1_running_k", 64'(ah_jrunning), 64'(k < 20));
        end
        eng_finished = '0;
        repeat (3) cyc();

        send(C_START, 64'hA5, 8'h3, 1'b0, 1'b0);
        repeat (2) cyc();
        eng_abort = 4'b0100;
        exp_q.push_back(64'h404);
        cyc();
        eng_abort = '0;
        chk("abort_running", 64'(ah_jrunning), 0);
        repeat (3) cyc();

        send(C_START, 64'hB6, 8'h4, 1'b0, 1'b0);
        cyc();
        drive(C_RESET, 64'h0, 8'h0, 1'b1, 1'b0);
        #1;
        chk("reset_cmd_received", 64'(reset_cmd_received), 1);
        cyc();
        ha_jval = 1'b0;
        chk("reset_clears_running", 64'(ah_jrunning), 0);
        reset_seq(30, 1'b0);

        send(C_RESET, 64'h0, 8'h0, 1'b0, 1'b0);
        reset_seq(18, 1'b0);
        send(C_RESET, 64'h0, 8'h0, 1'b0, 1'b0);
        reset_seq(30, 1'b0);

        send(C_RESET, 64'h0, 8'h0, 1'b0, 1'b0);
        reset_seq(30, 1'b1);
        repeat (4) cyc();

        for (int j = 0; j < 40; j++) begin
            ea = {$urandom, $urandom};
            cr = 8'($urandom);
            fin = '0;
            ab = '0;
            busy_done = 1'b0;
            done = 1'b0;
            allow_ab = bit'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                bjc = bit'($urandom_range(0, 1));
                bje = bjc ? bit'($urandom_range(0, 1)) : 1'b1;
                exp_q.push_back(64'({bje, bjc}));
                send(C_START, ea, cr, bjc, bje);
                cyc();
            end
            eng_finished = NE'($urandom);
            eng_abort = NE'($urandom);
            send(C_START, ea, cr, 1'b0, 1'b0);
            eng_finished = '0;
            eng_abort = '0;
            chk("rnd_wed", wed, ea);
            chk("rnd_credits", 64'(num_credits), 64'(cr));
            chk("rnd_running", 64'(ah_jrunning), 1);
            for (int c = 0; c < 200 && !done; c++) begin
                f = (c >= 60) ? '1 : NE'($urandom & $urandom);
                a = (allow_ab && $urandom_range(0, 24) == 0) ? NE'(1 << $urandom_range(0, NE - 1)) : '0;
                eng_finished = f;
                eng_abort = a;
                if (!busy_done && $urandom_range(0, 9) == 0) begin
                    drive(C_START, ~ea, 8'hFF, 1'b0, 1'b0);
                    exp_q.push_back(64'h8);
                    busy_done = 1'b1;
                end
                fin |= f;
                ab |= a;
                if (&fin || ab != 0) begin
                    exp_q.push_back((64'(ab) << 8) | (64'(ab != 0) << 2));
                    done = 1'b1;
                end
                cyc();
                ha_jval = 1'b0;
                eng_finished = '0;
                eng_abort = '0;
                chk("rnd_running_c", 64'(ah_jrunning), 64'(!done));
            end
            repeat (3) cyc();
            chk("rnd_wed_hold", wed, ea);
        end

        repeat (10) cyc();
        chk("queue_empty", 64'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
